// File: rtl/calendar_date_ctrl.sv
// BCD year/month/day calendar with a day-advance path and a three-field set mode.
// Optional feature: define LEAP_YEAR_EN to give February 29 days in years divisible by 4.
module calendar_date_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       day_tick,
    input  logic       set_btn,
    input  logic       up_btn,
    output logic [3:0] year1,
    output logic [3:0] year0,
    output logic [3:0] month1,
    output logic [3:0] month0,
    output logic [3:0] day1,
    output logic [3:0] day0,
    output logic [1:0] mode,
    output logic       year_tick
);

    typedef enum logic [1:0] {
        S_RUN       = 2'd0,
        S_SET_YEAR  = 2'd1,
        S_SET_MONTH = 2'd2,
        S_SET_DAY   = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_state_next;

    logic [7:0] r_year;
    logic [7:0] r_month;
    logic [7:0] r_day;
    logic       r_year_tick;

    logic [7:0] w_year_next;
    logic [7:0] w_month_next;
    logic [7:0] w_day_next;
    logic       w_year_tick_next;

    logic [7:0] w_dmax;
    logic [7:0] w_feb_len;
    logic [7:0] w_year_inc;
    logic [7:0] w_month_inc;
    logic [7:0] w_day_inc;
    logic       w_day_at_max;
    logic       w_month_at_max;

`ifdef LEAP_YEAR_EN
    logic w_leap;

    // Divisible by 4 in BCD: even tens with units 0/4/8, odd tens with units 2/6.
    always_comb begin
        if (!r_year[4])
            w_leap = (r_year[3:0] == 4'd0) || (r_year[3:0] == 4'd4) || (r_year[3:0] == 4'd8);
        else
            w_leap = (r_year[3:0] == 4'd2) || (r_year[3:0] == 4'd6);
    end

    assign w_feb_len = w_leap ? 8'h29 : 8'h28;
`else
    assign w_feb_len = 8'h28;
`endif

    always_comb begin
        case (r_month)
            8'h01, 8'h03, 8'h05, 8'h07, 8'h08, 8'h10, 8'h12: w_dmax = 8'h31;
            8'h02:                                           w_dmax = w_feb_len;
            default:                                         w_dmax = 8'h30;
        endcase
    end

    // Packed BCD compares numerically, so >= against dmax is a valid range check.
    assign w_day_at_max   = (r_day >= w_dmax);
    assign w_month_at_max = (r_month >= 8'h12);

    always_comb begin
        if (r_year[3:0] == 4'd9)
            w_year_inc = (r_year[7:4] == 4'd9) ? 8'h00 : {r_year[7:4] + 4'd1, 4'd0};
        else
            w_year_inc = {r_year[7:4], r_year[3:0] + 4'd1};
    end

    always_comb begin
        if (w_month_at_max)
            w_month_inc = 8'h01;
        else if (r_month[3:0] == 4'd9)
            w_month_inc = 8'h10;
        else
            w_month_inc = {r_month[7:4], r_month[3:0] + 4'd1};
    end

    assign w_day_inc = (r_day[3:0] == 4'd9) ? {r_day[7:4] + 4'd1, 4'd0}
                                            : {r_day[7:4], r_day[3:0] + 4'd1};

    always_comb begin
        w_state_next     = r_state;
        w_year_next      = r_year;
        w_month_next     = r_month;
        w_day_next       = r_day;
        w_year_tick_next = 1'b0;

        if (set_btn) begin
            case (r_state)
                S_RUN:       w_state_next = S_SET_YEAR;
                S_SET_YEAR:  w_state_next = S_SET_MONTH;
                S_SET_MONTH: w_state_next = S_SET_DAY;
                default:     w_state_next = S_RUN;
            endcase
            // Leaving a year/month edit can shorten the month; pull the day back in range.
            if ((r_state == S_SET_YEAR || r_state == S_SET_MONTH) && (r_day > w_dmax))
                w_day_next = w_dmax;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (day_tick) begin
                        if (!w_day_at_max) begin
                            w_day_next = w_day_inc;
                        end else begin
                            w_day_next   = 8'h01;
                            w_month_next = w_month_inc;
                            if (w_month_at_max) begin
                                w_year_next      = w_year_inc;
                                w_year_tick_next = 1'b1;
                            end
                        end
                    end
                end
                S_SET_YEAR: begin
                    if (up_btn)
                        w_year_next = w_year_inc;
                end
                S_SET_MONTH: begin
                    if (up_btn)
                        w_month_next = w_month_inc;
                end
                default: begin
                    if (up_btn)
                        w_day_next = w_day_at_max ? 8'h01 : w_day_inc;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_year      <= 8'h00;
            r_month     <= 8'h01;
            r_day       <= 8'h01;
            r_year_tick <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_year      <= w_year_next;
            r_month     <= w_month_next;
            r_day       <= w_day_next;
            r_year_tick <= w_year_tick_next;
        end
    end

    assign year1     = r_year[7:4];
    assign year0     = r_year[3:0];
    assign month1    = r_month[7:4];
    assign month0    = r_month[3:0];
    assign day1      = r_day[7:4];
    assign day0      = r_day[3:0];
    assign mode      = r_state;
    assign year_tick = r_year_tick;

endmodule
